// File: rtl/senha_game_ctrl_if.sv
// Guess/key inputs and result outputs of the password game controller.
// master drives the switches and key; slave is the controller.
interface senha_game_ctrl_if;
  logic [6:0] SW;
  logic       enter;
  logic [2:0] match_count;
  logic       match_valid;
  logic [1:0] level;
  logic [2:0] tries_left;
  logic       win;
  logic       lose;

  modport master (
    output SW, enter,
    input  match_count, match_valid, level, tries_left, win, lose
  );

  modport slave (
    input  SW, enter,
    output match_count, match_valid, level, tries_left, win, lose
  );
endinterface

// File: rtl/senha_game_ctrl.sv
// Password game: debounced key, 3-level secret match, tries and win/lose; GAME_RETRY_EN allows restart.
// match_valid strobes 2 cycles after the debounced key rises; no backpressure, the strobe is fire-and-forget.
module senha_game_ctrl #(
  parameter int         DEB_CYCLES = 500000,
  parameter int         MAX_TRIES  = 5,
  parameter logic [6:0] SENHA1     = 7'b0000000,
  parameter logic [6:0] SENHA2     = 7'b0000001,
  parameter logic [6:0] SENHA3     = 7'b1010101
) (
  input logic           clk,
  input logic           rst_n,
  senha_game_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEB_CYCLES);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT_REL, WIN, LOSE} state_t;

  state_t     state;
  logic [1:0] sync_q;
  logic       key_db;
  logic       key_db_q;
  logic [CW-1:0] deb_cnt;
  logic [6:0] guess_q;
  logic [6:0] secret;
  logic [2:0] hits;
  logic       press;

  logic [2:0] match_count_q;
  logic       match_valid_q;
  logic [1:0] level_q;
  logic [2:0] tries_q;
  logic       win_q;
  logic       lose_q;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 7; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  always_comb begin
    secret = SENHA3;
    case (level_q)
      2'd0:    secret = SENHA1;
      2'd1:    secret = SENHA2;
      default: secret = SENHA3;
    endcase
  end

  assign hits  = popcount7(~(guess_q ^ secret));
  assign press = key_db & ~key_db_q;

  // Flops reset to 1 so a key held through reset looks already pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      sync_q   <= {sync_q[0], bus.enter};
      key_db_q <= key_db;
      if (sync_q[1] == key_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
        deb_cnt <= '0;
        key_db  <= sync_q[1];
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_REL;
      guess_q       <= '0;
      match_count_q <= '0;
      match_valid_q <= 1'b0;
      level_q       <= '0;
      tries_q       <= 3'(MAX_TRIES);
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      match_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            guess_q <= bus.SW;
            state   <= CHECK;
          end
        end
        CHECK: begin
          match_count_q <= hits;
          match_valid_q <= 1'b1;
          state         <= WAIT_REL;
          if (hits == 3'd7) begin
            if (level_q < 2'd2) begin
              level_q <= level_q + 1'b1;
              tries_q <= 3'(MAX_TRIES);
            end else begin
              win_q <= 1'b1;
              state <= WIN;
            end
          end else if (tries_q > 3'd1) begin
            tries_q <= tries_q - 1'b1;
          end else begin
            tries_q <= '0;
            lose_q  <= 1'b1;
            state   <= LOSE;
          end
        end
        WAIT_REL: begin
          if (!key_db) state <= IDLE;
        end
        WIN, LOSE: begin
`ifdef GAME_RETRY_EN
          // Restart press is swallowed: WAIT_REL needs a release first.
          if (press) begin
            level_q       <= '0;
            tries_q       <= 3'(MAX_TRIES);
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            match_count_q <= '0;
            state         <= WAIT_REL;
          end
`else
          state <= state;
`endif
        end
        default: state <= WAIT_REL;
      endcase
    end
  end

  assign bus.match_count = match_count_q;
  assign bus.match_valid = match_valid_q;
  assign bus.level       = level_q;
  assign bus.tries_left  = tries_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;

endmodule

// File: tb/tb_senha_game_ctrl.sv
// Directed bench for senha_game_ctrl with DEB_CYCLES=4, MAX_TRIES=3.
module tb_senha_game_ctrl;
  localparam int DEB = 4;
  localparam int MT  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  senha_game_ctrl_if bus_if();

  senha_game_ctrl #(.DEB_CYCLES(DEB), .MAX_TRIES(MT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       do_rst;
    logic [6:0] sw;
    int         strobes;
    logic [2:0] cnt;
    logic [1:0] lvl;
    logic [2:0] tries;
    logic       win;
    logic       lose;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] cnt, input logic [1:0] lvl,
                            input logic [2:0] tries, input logic win, input logic lose);
    check({tag, ".match_count"}, 32'(bus_if.match_count), 32'(cnt));
    check({tag, ".level"},       32'(bus_if.level),       32'(lvl));
    check({tag, ".tries_left"},  32'(bus_if.tries_left),  32'(tries));
    check({tag, ".win"},         32'(bus_if.win),         32'(win));
    check({tag, ".lose"},        32'(bus_if.lose),        32'(lose));
  endtask

  task automatic pulse_reset();
    bus_if.enter = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // One clean press/release; switches flip to garbage after the latch point.
  task automatic press(input logic [6:0] sw, output int nstb);
    nstb = 0;
    bus_if.SW    = sw;
    bus_if.enter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 11) bus_if.SW = ~sw;
      if (bus_if.match_valid) nstb++;
    end
    bus_if.enter = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.match_valid) nstb++;
    end
  endtask

  initial begin
    int nstb;
    int first;

    //           rst   sw          stb cnt lvl tries win lose
    vecs[0]  = '{1'b1, 7'b0000000, 1, 3'd7, 2'd1, 3'd3, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 7'b0000001, 1, 3'd7, 2'd2, 3'd3, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 7'b1010101, 1, 3'd7, 2'd2, 3'd3, 1'b1, 1'b0};
`ifdef GAME_RETRY_EN
    vecs[3]  = '{1'b0, 7'b0000000, 0, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0};
`else
    vecs[3]  = '{1'b0, 7'b0000000, 0, 3'd7, 2'd2, 3'd3, 1'b1, 1'b0};
`endif
    vecs[4]  = '{1'b1, 7'b0000000, 1, 3'd7, 2'd1, 3'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 7'b0000000, 1, 3'd6, 2'd1, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 7'b0000001, 1, 3'd7, 2'd2, 3'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 7'b0101010, 1, 3'd0, 2'd2, 3'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 7'b0101010, 1, 3'd0, 2'd2, 3'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 7'b0101010, 1, 3'd0, 2'd2, 3'd0, 1'b0, 1'b1};
`ifdef GAME_RETRY_EN
    vecs[10] = '{1'b0, 7'b0101010, 0, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0};
`else
    vecs[10] = '{1'b0, 7'b0101010, 0, 3'd0, 2'd2, 3'd0, 1'b0, 1'b1};
`endif

    // Reset with the key held: nothing counts until release and a new press.
    bus_if.SW    = 7'b0000000;
    bus_if.enter = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.match_valid", 32'(bus_if.match_valid), 32'd0);
    check_outs("rst", 3'd0, 2'd0, 3'(MT), 1'b0, 1'b0);
    rst_n = 1'b1;
    nstb = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.match_valid) nstb++;
    end
    bus_if.enter = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.match_valid) nstb++;
    end
    check("held_key.strobes", 32'(nstb), 32'd0);
    press(7'b0000000, nstb);
    check("held_key.press_strobes", 32'(nstb), 32'd1);
    check_outs("held_key", 3'd7, 2'd1, 3'(MT), 1'b0, 1'b0);

    // Reset landing in the CHECK cycle (7th negedge after the raw key rises).
    bus_if.SW    = 7'b0000001;
    bus_if.enter = 1'b1;
    repeat (7) @(negedge clk);
    check("chk.no_early_strobe", 32'(bus_if.match_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("chk_rst.match_valid", 32'(bus_if.match_valid), 32'd0);
    check_outs("chk_rst", 3'd0, 2'd0, 3'(MT), 1'b0, 1'b0);
    bus_if.enter = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nstb = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.match_valid) nstb++;
    end
    check("chk_rst.strobes", 32'(nstb), 32'd0);

    // Bouncy press: 1,0,1,0 then steady; strobe expected 8 cycles after final rise.
    pulse_reset();
    bus_if.SW = 7'b0000000;
    bus_if.enter = 1'b1; @(negedge clk);
    bus_if.enter = 1'b0; @(negedge clk);
    bus_if.enter = 1'b1; @(negedge clk);
    bus_if.enter = 1'b0; @(negedge clk);
    bus_if.enter = 1'b1;
    nstb = 0;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus_if.match_valid) begin
        nstb++;
        if (first < 0) first = i;
      end
    end
    bus_if.enter = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.match_valid) nstb++;
    end
    check("bounce.strobes", 32'(nstb), 32'd1);
    check("bounce.latency", 32'(first), 32'd8);
    check_outs("bounce", 3'd7, 2'd1, 3'(MT), 1'b0, 1'b0);

    for (int v = 0; v < 11; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      if (vecs[v].do_rst) pulse_reset();
      press(vecs[v].sw, nstb);
      check({tag, ".strobes"}, 32'(nstb), 32'(vecs[v].strobes));
      check_outs(tag, vecs[v].cnt, vecs[v].lvl, vecs[v].tries, vecs[v].win, vecs[v].lose);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
